// File: rtl/y_pkg.sv
// y_pkg: Y memory geometry, slot value type, update FSM states and slot access helpers.
package y_pkg;
   localparam int SLOT_W = 64;
   localparam int VAL_W  = 24;
   localparam int SLOTS  = 4;
   localparam int ADDR_W = 11;
   localparam int WORD_W = 256;

   typedef struct packed {
      logic [VAL_W-1:0] re;
      logic [VAL_W-1:0] im;
   } y_val_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_MOD  = 2'd2,
      ST_WR   = 2'd3
   } y_state_e;

   function automatic logic [SLOT_W-1:0] slot_get(input logic [WORD_W-1:0] word,
                                                  input logic [$clog2(SLOTS)-1:0] slot);
      return word[int'(slot)*SLOT_W +: SLOT_W];
   endfunction

   // Only the 48-bit value field is replaced; the slot's upper pad bits survive untouched.
   function automatic logic [WORD_W-1:0] slot_put(input logic [WORD_W-1:0] word,
                                                  input logic [$clog2(SLOTS)-1:0] slot,
                                                  input y_val_t val);
      logic [WORD_W-1:0] res;
      res = word;
      res[int'(slot)*SLOT_W +: 2*VAL_W] = val;
      return res;
   endfunction
endpackage

// File: rtl/y_slot_add.sv
// y_slot_add: complex 24-bit delta add for one Y slot.
// Wraps modulo 2^24 by default; with Y_SAT_EN defined each part saturates on signed overflow.
module y_slot_add
   import y_pkg::*;
(
   input  y_val_t a_i,
   input  y_val_t b_i,
   output y_val_t sum_o
);

   function automatic logic [VAL_W-1:0] add_part(input logic [VAL_W-1:0] a,
                                                 input logic [VAL_W-1:0] b);
      logic [VAL_W-1:0] s;
      s = a + b;
`ifdef Y_SAT_EN
      if ((a[VAL_W-1] == b[VAL_W-1]) && (s[VAL_W-1] != a[VAL_W-1])) begin
         s = a[VAL_W-1] ? {1'b1, {(VAL_W-1){1'b0}}} : {1'b0, {(VAL_W-1){1'b1}}};
      end else begin
         s = a + b;
      end
`endif
      return s;
   endfunction

   assign sum_o.re = add_part(a_i.re, b_i.re);
   assign sum_o.im = add_part(a_i.im, b_i.im);

endmodule

// File: rtl/y_update_ctrl.sv
// y_update_ctrl: read-modify-write sequencer for the Y admittance SRAM plus single-entry readout.
// Build option: define Y_SAT_EN to make the delta adds saturate instead of wrap.
module y_update_ctrl
   import y_pkg::*;
#(
   parameter int NCOLS = 64,
   parameter int NROWS = 32,
   parameter int CNT_W = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                upd_valid,
   output logic                upd_ready,
   input  logic [15:0]         upd_row,
   input  logic [15:0]         upd_col,
   input  logic [VAL_W-1:0]    upd_real,
   input  logic [VAL_W-1:0]    upd_img,
   input  logic                rq_valid,
   input  logic [15:0]         rq_row,
   input  logic [15:0]         rq_col,
   output logic [2*VAL_W-1:0]  op_yval,
   output logic                op_yval_valid,
   output logic [ADDR_W-1:0]   y_rd_addr1,
   input  logic [WORD_W-1:0]   y_rd_data1,
   output logic [ADDR_W-1:0]   y_rd_addr2,
   input  logic [WORD_W-1:0]   y_rd_data2,
   output logic [ADDR_W-1:0]   y_wr_addr,
   output logic [WORD_W-1:0]   y_wr_data,
   output logic                y_we,
   output logic                busy,
   output logic [CNT_W-1:0]    upd_count
);

   localparam int COL_B = $clog2(NCOLS);
   localparam int ROW_B = $clog2(NROWS);
   localparam int LIN_W = ROW_B + COL_B;

   y_state_e            state_q;
   logic                ready_q, busy_q, we_q;
   logic [ADDR_W-1:0]   addr_q, wr_addr_q, addr2_q;
   logic [1:0]          slot_q, rq_slot_q;
   y_val_t              delta_q;
   logic [WORD_W-1:0]   wr_data_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                rq_pend_q, rq_fwd_q, yval_v_q;
   logic [2*VAL_W-1:0]  yval_q;

   logic [LIN_W-1:0]    upd_lin_s, rq_lin_s;
   logic [ADDR_W-1:0]   upd_addr_s, rq_addr_s;
   logic [SLOT_W-1:0]   old_slot_s, rd_slot_s;
   logic [WORD_W-1:0]   rd_word_s, wr_data_d;
   y_val_t              old_s, sum_s;
   logic                unused_s;

   // NCOLS is a power of two, so row*NCOLS+col is plain concatenation of the low index bits.
   assign upd_lin_s  = {upd_row[ROW_B-1:0], upd_col[COL_B-1:0]};
   assign rq_lin_s   = {rq_row[ROW_B-1:0], rq_col[COL_B-1:0]};
   assign upd_addr_s = ADDR_W'(upd_lin_s[LIN_W-1:2]);
   assign rq_addr_s  = ADDR_W'(rq_lin_s[LIN_W-1:2]);

   assign old_slot_s = slot_get(y_rd_data1, slot_q);
   assign old_s      = y_val_t'(old_slot_s[2*VAL_W-1:0]);
   assign wr_data_d  = slot_put(y_rd_data1, slot_q, sum_s);

   y_slot_add u_add (
      .a_i   (old_s),
      .b_i   (delta_q),
      .sum_o (sum_s)
   );

   // A write in the request cycle lands after the SRAM read, so the written word is forwarded.
   assign rd_word_s = rq_fwd_q ? wr_data_q : y_rd_data2;
   assign rd_slot_s = slot_get(rd_word_s, rq_slot_q);

   assign unused_s = ^{old_slot_s[SLOT_W-1:2*VAL_W], rd_slot_s[SLOT_W-1:2*VAL_W],
                       upd_row[15:ROW_B], upd_col[15:COL_B], rq_row[15:ROW_B], rq_col[15:COL_B]};

   // Update FSM: IDLE accepts a record, RD addresses port 1, MOD merges the delta, WR commits.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= {ADDR_W{1'b0}};
         wr_addr_q <= {ADDR_W{1'b0}};
         wr_data_q <= {WORD_W{1'b0}};
         slot_q    <= 2'd0;
         delta_q   <= {(2*VAL_W){1'b0}};
         cnt_q     <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               we_q <= 1'b0;
               if (upd_valid && ready_q) begin
                  addr_q   <= upd_addr_s;
                  slot_q   <= upd_lin_s[1:0];
                  delta_q  <= '{re: upd_real, im: upd_img};
                  ready_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= ST_RD;
               end else begin
                  ready_q  <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_RD: begin
               state_q <= ST_MOD;
            end
            ST_MOD: begin
               wr_data_q <= wr_data_d;
               wr_addr_q <= addr_q;
               we_q      <= 1'b1;
               state_q   <= ST_WR;
            end
            ST_WR: begin
               we_q    <= 1'b0;
               cnt_q   <= cnt_q + CNT_W'(1);
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               we_q    <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Readout pipeline on port 2, independent of the update FSM.
   always_ff @(posedge clock) begin
      if (!reset) begin
         addr2_q   <= {ADDR_W{1'b0}};
         rq_slot_q <= 2'd0;
         rq_pend_q <= 1'b0;
         rq_fwd_q  <= 1'b0;
         yval_q    <= {(2*VAL_W){1'b0}};
         yval_v_q  <= 1'b0;
      end else begin
         rq_pend_q <= rq_valid;
         yval_v_q  <= rq_pend_q;
         if (rq_valid) begin
            addr2_q   <= rq_addr_s;
            rq_slot_q <= rq_lin_s[1:0];
            rq_fwd_q  <= we_q && (wr_addr_q == rq_addr_s);
         end else begin
            addr2_q   <= addr2_q;
            rq_slot_q <= rq_slot_q;
            rq_fwd_q  <= rq_fwd_q;
         end
         if (rq_pend_q) begin
            yval_q <= rd_slot_s[2*VAL_W-1:0];
         end else begin
            yval_q <= yval_q;
         end
      end
   end

   assign upd_ready     = ready_q;
   assign busy          = busy_q;
   assign y_we          = we_q;
   assign y_rd_addr1    = addr_q;
   assign y_wr_addr     = wr_addr_q;
   assign y_wr_data     = wr_data_q;
   assign upd_count     = cnt_q;
   assign y_rd_addr2    = rq_valid ? rq_addr_s : addr2_q;
   assign op_yval       = yval_q;
   assign op_yval_valid = yval_v_q;

endmodule

// File: doc/y_update_ctrl.md
Name: y_update_ctrl

Overview:
- Sequences read-modify-write updates of the Y admittance SRAM from change.txt records (row, col, delta real, delta imag).
- Also serves single-entry Y readout requests.
- Sits between the change-record source and the dual-read/single-write Y memory, in place of direct myDesign-to-memory wiring.
- Owns read port 1 and the write port for updates, and read port 2 for readout.

Parameters:
- NCOLS, 64: columns per Y row; power of two, multiple of 4.
- NROWS, 32: number of Y rows; NROWS*NCOLS/4 <= 2048.
- CNT_W, 16: width of the completed-update counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- upd_valid  in  1  change record offered.
- upd_ready  out  1  controller accepts a record this cycle.
- upd_row  in  16  Y row index.
- upd_col  in  16  Y column index.
- upd_real  in  24  signed delta, real part.
- upd_img  in  24  signed delta, imaginary part.
- rq_valid  in  1  readout request.
- rq_row  in  16  readout row.
- rq_col  in  16  readout column.
- op_yval  out  48  readout value {real[23:0], img[23:0]}.
- op_yval_valid  out  1  op_yval valid pulse.
- y_rd_addr1  out  11  SRAM read address, port 1.
- y_rd_data1  in  256  SRAM read data, port 1.
- y_rd_addr2  out  11  SRAM read address, port 2.
- y_rd_data2  in  256  SRAM read data, port 2.
- y_wr_addr  out  11  SRAM write address.
- y_wr_data  out  256  SRAM write data.
- y_we  out  1  SRAM write enable.
- busy  out  1  high when FSM is not IDLE.
- upd_count  out  CNT_W  completed updates, wraps at 2^CNT_W.

Behaviour:
- Memory model: synchronous read; data for the address presented in cycle N appears in cycle N+1. Write commits at the edge ending the cycle where y_we=1.
- Layout: each 256-bit word holds 4 slots of 64 bits; slot k = bits [64k+63:64k] = {16'h0, real24, img24}.
- Addressing: lin = row*NCOLS + col; word address = lin>>2; slot = lin[1:0]. Indices use only their low log2 bits; out-of-range high bits are ignored.
- Reset (reset==0 at clock edge): state=IDLE; upd_ready=1; y_we=0; op_yval=0; op_yval_valid=0; upd_count=0; busy=0; all address/data outputs 0. Reset mid-operation abandons the update with no write.
- Update FSM, 4 cycles per update, states IDLE -> RD -> MOD -> WR -> IDLE:
  - IDLE: upd_ready=1. Handshake upd_valid&upd_ready latches the record and computes address/slot; next state RD.
  - RD: y_rd_addr1 = latched address; upd_ready=0.
  - MOD: y_rd_data1 is valid. Compute new slot real = old real + upd_real and img = old img + upd_img, each 24-bit two's-complement, wrapping by default. Replace only the target slot; other slots and all upper 16 bits pass through unchanged. Register the result as y_wr_data.
  - WR: y_we=1 for exactly one cycle with y_wr_addr/y_wr_data; upd_count increments; next state IDLE.
- Updates never overlap. The RD read of a following update occurs at least one cycle after the prior write commits, so no forwarding is needed on port 1.
- Readout:
  - rq_valid in cycle N: y_rd_addr2 = word address (combinational from rq_row/rq_col). Slot index is registered.
  - Cycle N+1: op_yval = selected slot[47:0] and op_yval_valid=1, both registered, so visible in cycle N+2.
  - Readout is always accepted and may be issued every cycle, independent of the update FSM.
- Read/write collision: if y_we=1 in cycle N to the same word as y_rd_addr2, the selected slot is taken from the written word rather than the SRAM data (write-through forwarding).
- y_rd_addr1 holds its last value outside RD/MOD. y_rd_addr2 holds its last value when rq_valid=0.

Optional Feature:
- Y_SAT_EN defined: real and img adds saturate independently to +8388607 / -8388608 on signed overflow.
- Y_SAT_EN undefined: adds wrap modulo 2^24.
- No other behavioural difference.

Decomposition:
- Package y_pkg holds:
  - constants SLOT_W=64, VAL_W=24, SLOTS=4, ADDR_W=11, WORD_W=256;
  - typedef y_val_t {real, img};
  - function for slot extract/insert.
- One sub-module, y_slot_add: combinational 24-bit complex add (wrap or saturate per Y_SAT_EN), instantiated in MOD.

Test Plan:
- Reset then single update: SRAM word 0 all zero; upd (row 0, col 1, real 5, img -3) -> y_we one cycle, 4 cycles after the handshake, addr 0, slot1 = {16'h0, 24'h000005, 24'hFFFFFD}; other slots 0; upd_count=1.
- Slot preservation: word 0x011 preloaded with per-slot pattern (upper bits included); update row 1, col 6 -> only slot 2 changes, all other bits are bit-exact.
- Back-to-back: upd_valid held for 3 records to the same entry (+1 each) -> upd_ready low for 3 of every 4 cycles; final value = preload + 3; upd_count=3.
- Overflow: entry real = 0x7FFFFF plus 1 -> 0x800000 without Y_SAT_EN, 0x7FFFFF with Y_SAT_EN.
- Readout collision: rq_valid to the word in the same cycle as y_we for that word -> op_yval two cycles later equals the newly written value.
- Reset mid-update: reset asserted in MOD -> no y_we, state IDLE, upd_count unchanged; SRAM unmodified.
